// File: rtl/pbfdaf_mode_ctrl_pkg.sv
// Shared definitions for the PBFDAF decision-stage mode controller.
package pbfdaf_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DD    = 2'd2
  } mode_t;

  // Width of the training-block and consecutive-bad-block counters.
  localparam int unsigned BLK_CW   = 8;
  // Width of the DD-to-TRAIN fallback counter.
  localparam int unsigned RELOCK_W = 8;

  // Decided-symbol amplitude: +1.0 in the fixed-point format.
  function automatic int amp_of(input int frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/pbfdaf_mode_ctrl_blk_err_cnt.sv
// Per-block bad-sample counter, bad-block flag and consecutive-bad-block
// counter. Cleared by a block start (i_first) or by clr (mode change/stop).
module pbfdaf_blk_err_cnt
  import pbfdaf_mode_ctrl_pkg::*;
#(
  parameter int EW      = 10,
  parameter int LOSS_TH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              smp,
  input  logic              first,
  input  logic              last,
  input  logic              bad,
  input  logic              dd,
  output logic [EW-1:0]     cur_cnt,
  output logic [BLK_CW-1:0] consec_nxt
);

  localparam logic [EW-1:0] LOSS_TH_V = EW'(LOSS_TH);

  logic [EW-1:0]     cnt;
  logic [EW-1:0]     base;
  logic [BLK_CW-1:0] consec;
  logic              blk_bad;

  // Count including the current sample; a first sample starts from zero.
  always_comb begin
    base       = first ? '0 : cnt;
    cur_cnt    = (bad && (base != '1)) ? base + EW'(1) : base;
    blk_bad    = (cur_cnt >= LOSS_TH_V);
    consec_nxt = '0;
    if (blk_bad) begin
      consec_nxt = (consec == '1) ? consec : consec + BLK_CW'(1);
    end
  end

  // Accumulate within a block; consecutive-bad count only advances in DD.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= '0;
      consec <= '0;
    end else if (smp) begin
      cnt <= last ? '0 : cur_cnt;
      if (last && dd) begin
        consec <= consec_nxt;
      end
    end
  end

endmodule

// File: rtl/pbfdaf_mode_ctrl.sv
// Decision-stage mode controller for the PBFDAF QPSK equalizer: selects the
// reference symbol (training or sign decision), emits the error sample, and
// sequences IDLE -> TRAIN -> DD with fallback to TRAIN on lost lock.
// Optional statistics ports are built when PBFDAF_MODE_STATS_EN is defined.
module pbfdaf_mode_ctrl
  import pbfdaf_mode_ctrl_pkg::*;
#(
  parameter int W          = 16,
  parameter int FRAC       = 15,
  parameter int AMP        = amp_of(FRAC),
  parameter int TRAIN_BLKS = 64,
  parameter int ERR_TH     = AMP >>> 1,
  parameter int LOSS_TH    = 8,
  parameter int LOSS_BLKS  = 4,
  parameter int EW         = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_valid,
  input  logic                i_first,
  input  logic                i_last,
  input  logic signed [W-1:0] i_y_re,
  input  logic signed [W-1:0] i_y_im,
  input  logic                i_tr_bI,
  input  logic                i_tr_bQ,
  output logic                o_valid,
  output logic                o_first,
  output logic                o_last,
  output logic signed [W:0]   o_err_re,
  output logic signed [W:0]   o_err_im,
  output logic                o_bI_hat,
  output logic                o_bQ_hat,
  output logic                o_train,
  output logic                o_adapt_en,
  output logic [1:0]          o_state,
  output logic [EW-1:0]       o_blk_bad_cnt,
  output logic [RELOCK_W-1:0] o_relock_cnt
);

  localparam logic signed [W:0]   AMP_V      = (W+1)'(AMP);
  localparam logic [W:0]          ERR_TH_V   = (W+1)'(ERR_TH);
  localparam logic [BLK_CW-1:0]   TRAIN_LAST = BLK_CW'(TRAIN_BLKS - 1);
  localparam logic [BLK_CW-1:0]   LOSS_BLK_V = BLK_CW'(LOSS_BLKS);

  mode_t             state;
  logic              synced;
  logic              hold;
  logic [BLK_CW-1:0] blk_cnt;

  logic              acc, in_train, in_dd;
  logic              ref_bi, ref_bq;
  logic signed [W:0] ref_re, ref_im, err_re, err_im;
  logic [W:0]        mag_re, mag_im;
  logic              bad, train_done, fallback, cnt_clr;
  logic [EW-1:0]     cur_cnt;
  logic [BLK_CW-1:0] consec_nxt;

  // Sample acceptance, reference selection, error and transition decisions.
  always_comb begin
    in_train   = (state == ST_TRAIN);
    in_dd      = (state == ST_DD);
    acc        = i_valid && !i_stop && (state != ST_IDLE) && (synced || i_first);
    ref_bi     = in_train ? i_tr_bI : i_y_re[W-1];
    ref_bq     = in_train ? i_tr_bQ : i_y_im[W-1];
    ref_re     = ref_bi ? -AMP_V : AMP_V;
    ref_im     = ref_bq ? -AMP_V : AMP_V;
    err_re     = ref_re - {i_y_re[W-1], i_y_re};
    err_im     = ref_im - {i_y_im[W-1], i_y_im};
    mag_re     = err_re[W] ? $unsigned(-err_re) : $unsigned(err_re);
    mag_im     = err_im[W] ? $unsigned(-err_im) : $unsigned(err_im);
    bad        = (mag_re > ERR_TH_V) || (mag_im > ERR_TH_V);
    train_done = acc && i_last && in_train && (blk_cnt == TRAIN_LAST);
    fallback   = acc && i_last && in_dd && (consec_nxt == LOSS_BLK_V);
    cnt_clr    = i_stop || (state == ST_IDLE) || train_done || fallback;
  end

  pbfdaf_blk_err_cnt #(
    .EW      (EW),
    .LOSS_TH (LOSS_TH)
  ) u_blk_err_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .smp        (acc),
    .first      (i_first),
    .last       (i_last),
    .bad        (bad),
    .dd         (in_dd),
    .cur_cnt    (cur_cnt),
    .consec_nxt (consec_nxt)
  );

  // Mode FSM with registered sample outputs; hold masks adaptation for the
  // first complete block after each mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      synced     <= 1'b0;
      hold       <= 1'b0;
      blk_cnt    <= '0;
      o_valid    <= 1'b0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
      o_err_re   <= '0;
      o_err_im   <= '0;
      o_bI_hat   <= 1'b0;
      o_bQ_hat   <= 1'b0;
      o_train    <= 1'b0;
      o_adapt_en <= 1'b0;
      o_state    <= ST_IDLE;
    end else begin
      o_valid    <= acc;
      o_first    <= acc && i_first;
      o_last     <= acc && i_last;
      o_train    <= acc && in_train;
      o_adapt_en <= acc && !hold;
      o_state    <= state;
      if (acc) begin
        o_err_re <= err_re;
        o_err_im <= err_im;
        o_bI_hat <= ref_bi;
        o_bQ_hat <= ref_bq;
      end
      if (i_stop) begin
        state   <= ST_IDLE;
        synced  <= 1'b0;
        o_state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              state   <= ST_TRAIN;
              synced  <= 1'b0;
              hold    <= 1'b1;
              blk_cnt <= '0;
            end
          end
          ST_TRAIN, ST_DD: begin
            if (acc) begin
              synced <= 1'b1;
              if (i_last) begin
                if (train_done) begin
                  state   <= ST_DD;
                  blk_cnt <= '0;
                  hold    <= 1'b1;
                end else if (fallback) begin
                  state   <= ST_TRAIN;
                  blk_cnt <= '0;
                  hold    <= 1'b1;
                end else begin
                  hold <= 1'b0;
                  if (in_train) begin
                    blk_cnt <= blk_cnt + BLK_CW'(1);
                  end
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef PBFDAF_MODE_STATS_EN
  logic [EW-1:0]       blk_bad_cnt_q;
  logic [RELOCK_W-1:0] relock_q;

  // Last completed block's bad count and saturating fallback count.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_bad_cnt_q <= '0;
      relock_q      <= '0;
    end else begin
      if (acc && i_last) begin
        blk_bad_cnt_q <= cur_cnt;
      end
      if (fallback && (relock_q != '1)) begin
        relock_q <= relock_q + RELOCK_W'(1);
      end
    end
  end

  assign o_blk_bad_cnt = blk_bad_cnt_q;
  assign o_relock_cnt  = relock_q;
`else
  logic stats_unused;
  assign stats_unused  = ^cur_cnt;
  assign o_blk_bad_cnt = '0;
  assign o_relock_cnt  = '0;
`endif

endmodule
